decoder_seq: RTL
================

Name: decoder_seq

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with a valid/ready input handshake.
- Adds a scan mode: starting from a given index, a walking one-hot output is generated automatically, one position per clock, with wrap-around.
- Used as the select/strobe generator for register-file write enables and memory-bank row scanning in the datapath.

Parameters:
- SEL_W, 3, width of the select input. Must be ≥ 1.
- OUT_W, 2**SEL_W, number of one-hot outputs. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable. When low, all state and outputs hold and in_ready=0.
- in_valid  input  1  request present on sel/mode.
- in_ready  output  1  block can accept a request.
- sel  input  SEL_W  decode index, or scan start index.
- mode  input  2  request mode: 00 DECODE, 01 SCAN, 10 CLEAR, 11 CLEAR (reserved alias).
- out_onehot  output  OUT_W  registered one-hot (or all-zero) output.
- out_valid  output  1  single-cycle pulse when out_onehot has taken a new value.
- scan_done  output  1  single-cycle pulse coincident with the last scan step.
- busy  output  1  high while state is SCAN.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - out_onehot=0, out_valid=0, scan_done=0, busy=0.
  - State=IDLE, step counter=0, scan index=0.
- in_ready = en & (state==IDLE). A request is accepted on a rising edge with in_valid & in_ready.
- IDLE, accept DECODE:
  - Next cycle: out_onehot = 1<<sel, out_valid=1 for one cycle.
  - The output holds until the next accepted request.
  - Latency: 1 clock.
- IDLE, accept CLEAR (mode 10 or 11):
  - Next cycle: out_onehot=0, out_valid=1 for one cycle.
- IDLE, accept SCAN:
  - Next cycle: state=SCAN, busy=1, out_onehot = 1<<sel, out_valid=1.
  - Index register = sel; step counter = 1.
- SCAN, each en-high cycle:
  - Index increments modulo OUT_W (OUT_W-1 wraps to 0).
  - out_onehot = 1<<index, out_valid=1, step counter +1.
- SCAN termination:
  - The OUT_W-th output emitted (every position visited exactly once) asserts scan_done=1 in the same cycle.
  - The following cycle returns to IDLE: busy=0, out_valid=0.
  - out_onehot holds its last value, i.e. 1<<((sel+OUT_W-1) mod OUT_W).
  - Total scan: OUT_W consecutive out_valid pulses (one per enabled cycle, with gaps where en is low), then 1 idle cycle before in_ready returns.
- en low: freezes state, counter, index and out_onehot. out_valid and scan_done are forced 0 during stalled cycles. The scan resumes exactly where it stopped.
- in_valid during SCAN: not accepted (in_ready=0). The requester must hold the request.
- SEL_W=1 edge case: a scan is 2 steps; scan_done is asserted on the second step.
- Step counter is SEL_W+1 bits wide so that the value OUT_W is representable.
- Invariant: out_onehot is always either zero or exactly one-hot.
- Reset mid-scan: immediate return to the reset values; no scan_done is emitted.

Decomposition:
- Package decoder_pkg holds:
  - Mode constants: MODE_DECODE=2'b00, MODE_SCAN=2'b01, MODE_CLEAR=2'b10.
  - State encoding: ST_IDLE, ST_SCAN.
- Sub-module onehot_dec: purely combinational, parametrised by SEL_W, maps an index to a 2^SEL_W one-hot vector. It is instantiated once, feeding the output register.
- decoder_seq holds the FSM, step counter, index register and handshake logic.

Test Plan (SEL_W=3):
- Reset then DECODE sel=5 → one cycle later out_onehot=8'b0010_0000, out_valid pulses once; in_ready=1 throughout.
- DECODE sel=0..7 back-to-back with in_valid held high → one-hot outputs 01,02,04,…,80 on consecutive cycles; never more than one bit set.
- SCAN sel=6 → out_onehot sequence 40,80,01,02,04,08,10,20 with busy=1 and in_ready=0. scan_done is coincident with 20; busy drops the next cycle; output holds 20.
- SCAN sel=0 with en low for 3 cycles after step 3 → output holds 04 with out_valid=0 during the stall; sequence resumes with 08 and exactly 8 out_valid pulses in total.
- DECODE sel=3, then CLEAR → out_onehot 08 then 00, with an out_valid pulse each; repeat with mode=11 for the same result.
- rst_n low asynchronously mid-scan (between clock edges) → out_onehot=0 and busy=0 immediately, no scan_done; after release a DECODE sel=2 gives 04.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants for the sequenced one-hot decoder:
// request mode encodings and the FSM state type.
package decoder_pkg;

    localparam logic [1:0] MODE_DECODE = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot mapper.
// Ports: idx_i (SEL_W index) -> onehot_o (2^SEL_W bits).
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx_i,
    output logic [2**SEL_W-1:0]   onehot_o
);

    localparam int OUT_W = 2**SEL_W;

    assign onehot_o = OUT_W'(1) << idx_i;

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready request and walking scan.
// Ports: clk, rst_n, en, in_valid/in_ready, sel, mode -> out_onehot,
//        out_valid, scan_done, busy.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    output logic [2**SEL_W-1:0]   out_onehot,
    output logic                  out_valid,
    output logic                  scan_done,
    output logic                  busy
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = SEL_W + 1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   idx_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SEL_W-1:0]   dec_idx;
    logic [OUT_W-1:0]   dec_oh;

    assign idx_inc = idx_q + SEL_W'(1);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // One decoder serves both paths: the request index in IDLE,
    // the next walking position while scanning.
    assign dec_idx = (state_q == ST_SCAN) ? idx_inc : sel;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx_i    (dec_idx),
        .onehot_o (dec_oh)
    );

    assign in_ready   = en & (state_q == ST_IDLE);
    assign out_onehot = out_q;
    assign out_valid  = vld_q;
    assign scan_done  = done_q;
    assign busy       = (state_q == ST_SCAN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        vld_d = 1'b1;
                        case (mode)
                            MODE_DECODE: out_d = dec_oh;
                            MODE_SCAN: begin
                                out_d   = dec_oh;
                                idx_d   = sel;
                                cnt_d   = CNT_W'(1);
                                state_d = ST_SCAN;
                            end
                            default: out_d = '0;
                        endcase
                    end
                end
                ST_SCAN: begin
                    // Counter reaching OUT_W means every position was
                    // emitted; spend one quiet cycle before idling.
                    if (cnt_q == CNT_W'(OUT_W)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        idx_d  = idx_inc;
                        cnt_d  = cnt_inc;
                        out_d  = dec_oh;
                        vld_d  = 1'b1;
                        done_d = (cnt_inc == CNT_W'(OUT_W));
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

endmodule
